data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the core's req/gnt/rvalid data-memory interface.
- It accepts one transaction at a time, executes word reads or byte-enabled writes on an internal single-port word array, and returns rvalid/rdata after a configurable latency.
- It sits between the core's data port and the system, and serves as the bench/FPGA data memory model.

Parameters:
- MEM_ADDR_WIDTH, 10, byte address width; the array holds 2**(MEM_ADDR_WIDTH-2) words.
- DATA_WIDTH, 32, word width.
- TRANSFER_WIDTH, 4, byte-enable width (DATA_WIDTH/8).
- GNT_WAIT, 0, cycles req_i must be held before gnt_o is asserted (0..7).
- LATENCY, 1, cycles from the grant cycle to the rvalid cycle (1..7).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_i  input  1  transaction request from the core.
- we_i  input  1  1 = write, 0 = read.
- addr_i  input  MEM_ADDR_WIDTH  byte address; bits [1:0] are ignored (word aligned).
- wdata_i  input  DATA_WIDTH  write data.
- be_i  input  TRANSFER_WIDTH  byte enables; bit k covers byte k.
- gnt_o  output  1  request accepted this cycle.
- rvalid_o  output  1  response valid; one-cycle pulse per granted transaction.
- rdata_o  output  DATA_WIDTH  read data, valid while rvalid_o=1.

Behaviour:
- Clocking/reset:
  - Single clock. Reset is asynchronous and active-low via rst_n.
  - Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, state=IDLE, all counters 0.
  - Array contents are not reset.
- States:
  - IDLE: no transaction outstanding.
  - WAIT: request seen, grant wait counter running.
  - BUSY: transaction granted, latency counter running.
- gnt_o (combinational from state and counter):
  - gnt_o = req_i & (state==IDLE or the rvalid cycle) & (wait_cnt==GNT_WAIT).
  - With GNT_WAIT=0, the grant occurs in the same cycle as req_i.
- WAIT handling:
  - IDLE with req_i=1 and GNT_WAIT>0: go to WAIT, wait_cnt=1.
  - WAIT: wait_cnt increments each cycle req_i stays high.
  - req_i low in WAIT: return to IDLE, wait_cnt=0; no access, no response.
- Grant edge (clock edge ending the grant cycle):
  - Latch we_i and addr_i[MEM_ADDR_WIDTH-1:2].
  - Write: for every k with be_i[k]=1, mem[word][8k+7:8k] <= wdata_i[8k+7:8k]. be_i=0 writes nothing but still produces a response.
  - Read: capture the full word; be_i is ignored.
  - Load lat_cnt=LATENCY; enter BUSY.
- BUSY:
  - lat_cnt decrements each cycle.
  - rvalid_o=1 for exactly one cycle, LATENCY cycles after the grant cycle (grant at cycle t, rvalid at t+LATENCY).
  - gnt_o=0 until the rvalid cycle.
- rdata_o:
  - Read response: the word as of the grant edge.
  - Write response: rdata_o=0.
  - Outside rvalid: holds its last value.
- Back-to-back:
  - In the rvalid cycle, a new req_i may be granted (GNT_WAIT=0), or may start WAIT with wait_cnt=1.
  - Peak throughput is one transaction per LATENCY cycles.
- Read-after-write: a read granted at t+LATENCY to the address written at grant t returns the new data.
- Reset mid-operation:
  - The pending response is discarded; rvalid_o never pulses for it.
  - A write already committed at its grant edge remains in the array.
- Requester rule: req_i, we_i, addr_i, wdata_i and be_i are stable from req rise until gnt. Inputs changing before grant are sampled only at the grant edge.
- Widths: no address range check; all 2**(MEM_ADDR_WIDTH-2) words are reachable, and upper address bits wrap naturally.

Test Plan:
- GNT_WAIT=0, LATENCY=1, write req addr=0x010, wdata=0xDEADBEEF, be=4'b1111 -> gnt_o=1 same cycle; rvalid_o=1 next cycle with rdata_o=0. Then a read at 0x010 -> rvalid one cycle after gnt, rdata_o=0xDEADBEEF.
- Byte enables: write 0x000000AA be=4'b0001, then 0x55000000 be=4'b1000 to 0x010 -> read returns 0x55ADBEAA. Write with be=0 -> rvalid pulses and word is unchanged.
- GNT_WAIT=2 -> req held 3 cycles gives gnt_o in the 3rd cycle. req dropped after 1 cycle -> no gnt, no rvalid, memory unchanged.
- LATENCY=3, read granted at cycle t -> rvalid_o only at t+3. A second req raised at t+1 -> gnt_o=0 at t+1 and t+2, granted at t+3, rvalid at t+6.
- Back-to-back with LATENCY=1: write 0x12345678 to 0x020, then immediately a read of 0x020 granted in the rvalid cycle -> rdata 0x12345678, with no idle cycle between the two transactions.
- Reset: LATENCY=4, write 0xCAFEF00D to 0x004, rst_n low at t+2 for one cycle -> all outputs 0 and no rvalid pulse. After reset, a read at 0x004 returns 0xCAFEF00D.

Source files
------------

// File: rtl/data_mem_if.sv
// Core data-memory bus (req/gnt/rvalid) as seen between a requester and the memory responder.
interface data_mem_if #(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int TRANSFER_WIDTH = 4
);
    logic                      req_i;
    logic                      we_i;
    logic [MEM_ADDR_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0]     wdata_i;
    logic [TRANSFER_WIDTH-1:0] be_i;
    logic                      gnt_o;
    logic                      rvalid_o;
    logic [DATA_WIDTH-1:0]     rdata_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i,
        output gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-port word memory answering req/gnt/rvalid transactions one at a time,
// with a programmable grant wait and response latency.
//
// state | meaning
// IDLE  | no transaction outstanding
// WAIT  | request seen, grant wait counter running
// BUSY  | transaction granted, latency counter running down to the rvalid cycle
module data_mem_responder #(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int TRANSFER_WIDTH = 4,
    parameter int GNT_WAIT       = 0,
    parameter int LATENCY        = 1
) (
    input logic         clk,
    input logic         rst_n,
    data_mem_if.slave   bus
);
    localparam int WORD_AW = MEM_ADDR_WIDTH - 2;
    localparam int WORDS   = 2 ** WORD_AW;

    typedef enum logic [1:0] {IDLE, WAIT, BUSY} state_t;

    state_t               state, state_d;
    logic [2:0]           wait_cnt, wait_d;
    logic [2:0]           lat_cnt, lat_d;
    logic                 we_q;
    logic [WORD_AW-1:0]   word_q;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] last_data;
    logic [DATA_WIDTH-1:0] mem [WORDS];
    logic                 grant;
    logic                 rvalid;
    logic [WORD_AW-1:0]   word;
    logic                 unused_addr;

    assign word        = bus.addr_i[MEM_ADDR_WIDTH-1:2];
    assign unused_addr = ^bus.addr_i[1:0];

    assign rvalid = (state == BUSY) && (lat_cnt == 3'd1);
    // rst_n gating keeps gnt_o low while reset is held even if req_i is high
    assign grant  = rst_n && bus.req_i && ((state != BUSY) || rvalid)
                    && (wait_cnt == 3'(GNT_WAIT));

    always_comb begin
        state_d = state;
        wait_d  = wait_cnt;
        lat_d   = lat_cnt;
        unique case (state)
            IDLE: begin
                if (bus.req_i) begin
                    state_d = WAIT;
                    wait_d  = 3'd1;
                end
            end
            WAIT: begin
                if (bus.req_i) begin
                    wait_d = wait_cnt + 3'd1;
                end else begin
                    state_d = IDLE;
                    wait_d  = 3'd0;
                end
            end
            BUSY: begin
                if (rvalid) begin
                    lat_d = 3'd0;
                    if (bus.req_i) begin
                        state_d = WAIT;
                        wait_d  = 3'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    lat_d = lat_cnt - 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                wait_d  = 3'd0;
                lat_d   = 3'd0;
            end
        endcase
        if (grant) begin
            state_d = BUSY;
            wait_d  = 3'd0;
            lat_d   = 3'(LATENCY);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= 3'd0;
            lat_cnt   <= 3'd0;
            we_q      <= 1'b0;
            word_q    <= '0;
            last_data <= '0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_d;
            lat_cnt  <= lat_d;
            if (grant) begin
                we_q   <= bus.we_i;
                word_q <= word;
            end
            if (rvalid) begin
                last_data <= bus.rdata_o;
            end
        end
    end

    // Array is deliberately outside reset so committed writes survive rst_n
    always_ff @(posedge clk) begin
        if (grant) begin
            if (bus.we_i) begin
                for (int k = 0; k < TRANSFER_WIDTH; k++) begin
                    if (bus.be_i[k]) begin
                        mem[word][8*k +: 8] <= bus.wdata_i[8*k +: 8];
                    end
                end
            end else begin
                rd_word <= mem[word];
            end
        end
    end

    assign bus.gnt_o    = grant;
    assign bus.rvalid_o = rvalid;
    assign bus.rdata_o  = rvalid ? (we_q ? '0 : rd_word) : last_data;
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: four responders with different GNT_WAIT/LATENCY driven by directed vectors.
module tb_data_mem_responder;
    localparam int N = 4;
    localparam int GW [N] = '{0, 2, 0, 0};
    localparam int LT [N] = '{1, 1, 3, 4};

    logic        clk = 1'b0;
    logic        rst_n [N];
    logic        req [N];
    logic        we [N];
    logic [9:0]  addr [N];
    logic [31:0] wdata [N];
    logic [3:0]  be [N];
    logic        gnt [N];
    logic        rvalid [N];
    logic [31:0] rdata [N];

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          done = 1'b0;
    int          exp_gnt [N][$];
    logic [63:0] exp_rsp [N][$];
    logic [31:0] hold [N];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : g_dut
        data_mem_if #(.MEM_ADDR_WIDTH(10), .DATA_WIDTH(32), .TRANSFER_WIDTH(4)) bus ();
        data_mem_responder #(
            .MEM_ADDR_WIDTH(10), .DATA_WIDTH(32), .TRANSFER_WIDTH(4),
            .GNT_WAIT(GW[g]), .LATENCY(LT[g])
        ) dut (
            .clk  (clk),
            .rst_n(rst_n[g]),
            .bus  (bus)
        );
        assign bus.req_i   = req[g];
        assign bus.we_i    = we[g];
        assign bus.addr_i  = addr[g];
        assign bus.wdata_i = wdata[g];
        assign bus.be_i    = be[g];
        assign gnt[g]      = bus.gnt_o;
        assign rvalid[g]   = bus.rvalid_o;
        assign rdata[g]    = bus.rdata_o;
    end

    // Called at posedge+1; returns at posedge+1 after the grant edge with req dropped.
    task automatic issue(input int i, input bit w, input logic [9:0] a, input logic [31:0] d,
                         input logic [3:0] b, input int dly, input bit rsp, input logic [31:0] exp_d);
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d; be[i] = b;
        exp_gnt[i].push_back(cyc + dly);
        if (rsp) exp_rsp[i].push_back({32'(cyc + dly + LT[i]), exp_d});
        repeat (dly + 1) @(posedge clk);
        #1 req[i] = 1'b0;
    endtask

    task automatic blip(input int i, input logic [9:0] a, input logic [31:0] d);
        req[i] = 1'b1; we[i] = 1'b1; addr[i] = a; wdata[i] = d; be[i] = 4'hF;
        @(posedge clk);
        #1 req[i] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst_n[i]) begin
                checks++;
                hold[i] = '0;
                if (gnt[i] !== 1'b0 || rvalid[i] !== 1'b0 || rdata[i] !== 32'h0) begin
                    errors++;
                    $display("FAIL reset_outputs inst %0d cyc %0d: gnt=%b rvalid=%b rdata=%h, required 0 0 00000000",
                             i, cyc, gnt[i], rvalid[i], rdata[i]);
                end
            end else begin
                if (gnt[i] !== 1'b0) begin
                    checks++;
                    if (exp_gnt[i].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_gnt inst %0d: gnt=%b at cyc %0d, required 0", i, gnt[i], cyc);
                    end else begin
                        int ec;
                        ec = exp_gnt[i].pop_front();
                        if (ec != cyc) begin
                            errors++;
                            $display("FAIL gnt_cycle inst %0d: got cyc %0d, required cyc %0d", i, cyc, ec);
                        end
                    end
                end
                if (rvalid[i] !== 1'b0) begin
                    checks++;
                    if (exp_rsp[i].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_rvalid inst %0d: rvalid=%b at cyc %0d, required 0", i, rvalid[i], cyc);
                    end else begin
                        logic [63:0] e;
                        e = exp_rsp[i].pop_front();
                        hold[i] = e[31:0];
                        if (e[63:32] != 32'(cyc) || rdata[i] !== e[31:0]) begin
                            errors++;
                            $display("FAIL rsp inst %0d: cyc %0d rdata %h, required cyc %0d rdata %h",
                                     i, cyc, rdata[i], e[63:32], e[31:0]);
                        end
                    end
                end else begin
                    checks++;
                    if (rdata[i] !== hold[i]) begin
                        errors++;
                        $display("FAIL rdata_hold inst %0d cyc %0d: rdata %h, required %h", i, cyc, rdata[i], hold[i]);
                    end
                end
            end
        end
        if (done || cyc > 5000) begin
            if (!done) begin
                errors++;
                $display("FAIL timeout: cyc %0d, required done before 5000", cyc);
            end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (exp_gnt[i].size() != 0 || exp_rsp[i].size() != 0) begin
                    errors++;
                    $display("FAIL missing_events inst %0d: gnt left %0d rsp left %0d, required 0 0",
                             i, exp_gnt[i].size(), exp_rsp[i].size());
                end
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            rst_n[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0;
            addr[i] = '0; wdata[i] = '0; be[i] = '0; hold[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
        idle(1);

        // GNT_WAIT=0, LATENCY=1: full write, read back, byte enables, be=0, back-to-back
        issue(0, 1, 10'h010, 32'hDEADBEEF, 4'hF, 0, 1, 32'h0);
        issue(0, 0, 10'h010, 32'h0,        4'hF, 0, 1, 32'hDEADBEEF);
        issue(0, 1, 10'h010, 32'h000000AA, 4'b0001, 0, 1, 32'h0);
        issue(0, 1, 10'h010, 32'h55000000, 4'b1000, 0, 1, 32'h0);
        issue(0, 0, 10'h010, 32'h0,        4'h0, 0, 1, 32'h55ADBEAA);
        idle(2);
        issue(0, 1, 10'h010, 32'hFFFFFFFF, 4'h0, 0, 1, 32'h0);
        issue(0, 0, 10'h010, 32'h0,        4'hF, 0, 1, 32'h55ADBEAA);
        idle(3);
        issue(0, 1, 10'h020, 32'h12345678, 4'hF, 0, 1, 32'h0);
        issue(0, 0, 10'h020, 32'h0,        4'hF, 0, 1, 32'h12345678);
        issue(0, 0, 10'h023, 32'h0,        4'hF, 0, 1, 32'h12345678);
        idle(3);

        // GNT_WAIT=2: grant in third held cycle, dropped request does nothing
        issue(1, 1, 10'h010, 32'hA5A5A5A5, 4'hF, 2, 1, 32'h0);
        blip(1, 10'h010, 32'h11111111);
        idle(3);
        issue(1, 0, 10'h010, 32'h0, 4'hF, 2, 1, 32'hA5A5A5A5);
        issue(1, 0, 10'h010, 32'h0, 4'hF, 2, 1, 32'hA5A5A5A5);
        idle(3);

        // LATENCY=3: requests raised while busy are held off until the rvalid cycle
        issue(2, 1, 10'h008, 32'h0BADCAFE, 4'hF, 0, 1, 32'h0);
        issue(2, 0, 10'h008, 32'h0,        4'hF, 2, 1, 32'h0BADCAFE);
        issue(2, 1, 10'h00C, 32'h00C0FFEE, 4'hF, 2, 1, 32'h0);
        issue(2, 0, 10'h00C, 32'h0,        4'hF, 2, 1, 32'h00C0FFEE);
        idle(4);

        // LATENCY=4: reset two cycles after grant drops the response, keeps the write
        issue(3, 1, 10'h004, 32'hCAFEF00D, 4'hF, 0, 0, 32'h0);
        idle(1);
        rst_n[3] = 1'b0;
        idle(1);
        rst_n[3] = 1'b1;
        idle(6);
        issue(3, 0, 10'h004, 32'h0, 4'hF, 0, 1, 32'hCAFEF00D);
        idle(6);

        done = 1'b1;
    end
endmodule
